// File: rtl/memory_stage.sv
// Y86-64 memory stage: 8-byte little-endian data memory access, forwarding
// outputs for decode/execute, and the W pipeline register for writeback.
module memory_stage #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [144:0] memory_reg,
    input  logic         W_stall,
    input  logic         W_bubble,
    output logic [140:0] writeback_reg,
    output logic [63:0]  m_valM,
    output logic [3:0]   m_dstM,
    output logic         m_status,
    output logic         W_status
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - 8);

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [140:0] W_BUBBLE = {1'b0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF};

    logic              in_status;
    logic [3:0]        icode;
    logic [63:0]       val_e;
    logic [63:0]       val_a;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic              unused_cnd;

    assign in_status  = memory_reg[144];
    assign icode      = memory_reg[143:140];
    assign unused_cnd = ^memory_reg[139:136];
    assign val_e      = memory_reg[135:72];
    assign val_a      = memory_reg[71:8];
    assign dst_e      = memory_reg[7:4];
    assign dst_m      = memory_reg[3:0];

    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              wr_en;
    logic              adr_err;
    logic              wr_commit;
    logic [63:0]       rd_data;
    logic [IDX_W-1:0]  byte_idx [8];
    logic [7:0]        mem [MEM_BYTES];

    always_comb begin
        addr  = '0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        case (icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: begin
                addr  = ADDR_W'(val_e);
                wr_en = 1'b1;
            end
            I_MRMOVQ: begin
                addr  = ADDR_W'(val_e);
                rd_en = 1'b1;
            end
            I_RET, I_POPQ: begin
                addr  = ADDR_W'(val_a);
                rd_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Full-width compare so huge addresses never alias back into the array.
    assign adr_err   = (rd_en | wr_en) && (addr > ADDR_LIMIT);
    assign m_status  = in_status | adr_err;
    assign m_dstM    = dst_m;
    assign m_valM    = (rd_en && !m_status) ? rd_data : 64'h0;
    assign wr_commit = wr_en && !m_status && !W_stall && !reset;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte_lane
            assign byte_idx[gi]         = addr[IDX_W-1:0] + IDX_W'(gi);
            assign rd_data[8*gi +: 8]   = mem[byte_idx[gi]];
        end
    endgenerate

    // Memory contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 8; i++) begin
                mem[byte_idx[i]] <= val_a[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            writeback_reg <= W_BUBBLE;
        end else if (W_stall) begin
            writeback_reg <= writeback_reg;
        end else if (W_bubble) begin
            writeback_reg <= W_BUBBLE;
        end else begin
            writeback_reg <= {m_status, icode, val_e, m_valM, dst_e, dst_m};
        end
    end

    assign W_status = writeback_reg[140];

endmodule
